// File: rtl/render_pkg.sv
// ============================================================================
// render_pkg
// Shared FSM state encoding, Q.15 constants and pixel saturation helper for
// the rotation scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package render_pkg;

  localparam int Q15_SHIFT = 15;
  localparam int PIX_MAX   = 511;
  localparam int PIX_W     = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    ROM_WAIT = 3'd2,
    LATCH    = 3'd3,
    FETCH    = 3'd4,
    MUL      = 3'd5,
    WRITE    = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Clamp a signed integer result onto the visible pixel range 0..PIX_MAX.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [64:0] v);
    logic [PIX_W-1:0] r;
    if (v[64]) begin
      r = '0;
    end else if (v > $signed(65'(PIX_MAX))) begin
      r = PIX_W'(PIX_MAX);
    end else begin
      r = v[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/q15_mac.sv
// ============================================================================
// q15_mac
// Single shared 32x32 signed multiplier feeding a 65-bit accumulator with
// clear/subtract control and a saturating Q.30 -> pixel output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module q15_mac
  import render_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    sub_i,
  input  logic signed [31:0]      a_i,
  input  logic signed [31:0]      b_i,
  output logic [PIX_W-1:0]        pix_o
);

  logic signed [63:0] prod;
  logic signed [64:0] prod_ext;
  logic signed [64:0] base;
  logic signed [64:0] acc_d;
  logic signed [64:0] acc_q;

  assign prod     = 64'(a_i) * 64'(b_i);
  assign prod_ext = 65'(prod);
  // clear_i starts a fresh sum with the current product instead of adding.
  assign base     = clear_i ? '0 : acc_q;
  assign acc_d    = sub_i ? (base - prod_ext) : (base + prod_ext);
  assign pix_o    = sat_pix(acc_d >>> (2 * Q15_SHIFT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rotation_scheduler.sv
// ============================================================================
// rotation_scheduler
// Per-frame angle stepping and vertex rotation pass; writes saturated pixel
// coordinates for 3*NUM_TRI vertices. Optional macro ROTATE_Y_EN adds y'.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rotation_scheduler
  import render_pkg::*;
#(
  parameter int NUM_TRI    = 6,
  parameter int NUM_ANGLES = 10,
  parameter int ROM_LAT    = 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                INCREMENT_ANGLE,
  input  logic                frame_start,
  input  logic signed [31:0]  sin_out,
  input  logic signed [31:0]  cos_out,
  output logic [4:0]          ANGLE_ADDRESS,
  output logic [7:0]          vtx_rd_idx,
  input  logic signed [31:0]  vtx_x_in,
  input  logic signed [31:0]  vtx_y_in,
  output logic                wr_en,
  output logic [7:0]          wr_idx,
  output logic [8:0]          wr_x,
  output logic [8:0]          wr_y,
  output logic                busy,
  output logic                frame_done
);

  localparam int NUM_VTX = 3 * NUM_TRI;
`ifdef ROTATE_Y_EN
  localparam int MUL_CYC = 4;
`else
  localparam int MUL_CYC = 2;
`endif
  localparam int RW_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_e             state_q, state_d;
  logic [4:0]         angle_q, angle_d;
  logic               pending_q, pending_d;
  logic [RW_W-1:0]    rw_cnt_q, rw_cnt_d;
  logic [7:0]         idx_q, idx_d;
  logic [1:0]         mstep_q, mstep_d;
  logic [7:0]         wr_idx_q, wr_idx_d;
  logic [8:0]         wr_x_q, wr_x_d;
  logic [8:0]         wr_y_q, wr_y_d;
  logic signed [31:0] sin_q, cos_q;
  logic signed [31:0] y_q;
`ifdef ROTATE_Y_EN
  logic signed [31:0] x_q;
`endif

  logic               latch_sc;
  logic               latch_vtx;
  logic               mac_en;
  logic               mac_clear;
  logic               mac_sub;
  logic signed [31:0] mac_a;
  logic signed [31:0] mac_b;
  logic [8:0]         mac_pix;

  q15_mac u_mac (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .en_i    (mac_en),
    .clear_i (mac_clear),
    .sub_i   (mac_sub),
    .a_i     (mac_a),
    .b_i     (mac_b),
    .pix_o   (mac_pix)
  );

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    pending_d = pending_q;
    rw_cnt_d  = rw_cnt_q;
    idx_d     = idx_q;
    mstep_d   = mstep_q;
    wr_idx_d  = wr_idx_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    latch_sc  = 1'b0;
    latch_vtx = 1'b0;
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    mac_sub   = 1'b0;
    mac_a     = vtx_x_in;
    mac_b     = cos_q;

    // Requests collapse into a single pending step wherever they arrive.
    if (INCREMENT_ANGLE) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (INCREMENT_ANGLE) state_d = ARMED;
      end
      ARMED: begin
        if (frame_start) begin
          if (pending_q) begin
            angle_d = (angle_q == 5'(NUM_ANGLES - 1)) ? 5'd0 : angle_q + 5'd1;
          end
          pending_d = INCREMENT_ANGLE;
          rw_cnt_d  = '0;
          idx_d     = '0;
          state_d   = ROM_WAIT;
        end
      end
      ROM_WAIT: begin
        if (rw_cnt_q == RW_W'(ROM_LAT - 1)) state_d = LATCH;
        else                                rw_cnt_d = rw_cnt_q + RW_W'(1);
      end
      LATCH: begin
        latch_sc = 1'b1;
        state_d  = FETCH;
      end
      FETCH: begin
        mstep_d = '0;
        state_d = MUL;
      end
      MUL: begin
        mac_en  = 1'b1;
        mstep_d = mstep_q + 2'd1;
        case (mstep_q)
          2'd0: begin
            mac_a     = vtx_x_in;
            mac_b     = cos_q;
            mac_clear = 1'b1;
            latch_vtx = 1'b1;
`ifndef ROTATE_Y_EN
            wr_y_d    = sat_pix(65'(vtx_y_in) >>> Q15_SHIFT);
`endif
          end
          2'd1: begin
            mac_a    = y_q;
            mac_b    = sin_q;
            wr_x_d   = mac_pix;
            wr_idx_d = idx_q;
          end
`ifdef ROTATE_Y_EN
          2'd2: begin
            mac_a     = x_q;
            mac_b     = sin_q;
            mac_clear = 1'b1;
            mac_sub   = 1'b1;
          end
          2'd3: begin
            mac_a  = y_q;
            mac_b  = cos_q;
            wr_y_d = mac_pix;
          end
`endif
          default: ;
        endcase
        if (mstep_q == 2'(MUL_CYC - 1)) state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == 8'(NUM_VTX - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = pending_d ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset arms the first pass so the opening frame renders at angle 0.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ARMED;
      angle_q   <= '0;
      pending_q <= 1'b0;
      rw_cnt_q  <= '0;
      idx_q     <= '0;
      mstep_q   <= '0;
      wr_idx_q  <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      y_q       <= '0;
`ifdef ROTATE_Y_EN
      x_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      pending_q <= pending_d;
      rw_cnt_q  <= rw_cnt_d;
      idx_q     <= idx_d;
      mstep_q   <= mstep_d;
      wr_idx_q  <= wr_idx_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      if (latch_sc) begin
        sin_q <= sin_out;
        cos_q <= cos_out;
      end
      if (latch_vtx) begin
        y_q <= vtx_y_in;
`ifdef ROTATE_Y_EN
        x_q <= vtx_x_in;
`endif
      end
    end
  end

  assign ANGLE_ADDRESS = angle_q;
  assign vtx_rd_idx    = idx_q;
  assign wr_en         = (state_q == WRITE);
  assign wr_idx        = wr_idx_q;
  assign wr_x          = wr_x_q;
  assign wr_y          = wr_y_q;
  assign busy          = (state_q == ROM_WAIT) || (state_q == LATCH) ||
                         (state_q == FETCH)    || (state_q == MUL)   ||
                         (state_q == WRITE);
  assign frame_done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_rotation_scheduler.sv
// ============================================================================
// tb_rotation_scheduler
// Directed self-checking bench for rotation_scheduler (honours ROTATE_Y_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotation_scheduler;

`ifdef ROTATE_Y_EN
  localparam int LAT_EXP  = 111;
  localparam int Y_ROT0   = 0;
  localparam int Y_ROT4   = 0;
`else
  localparam int LAT_EXP  = 75;
  localparam int Y_ROT0   = 120;
  localparam int Y_ROT4   = 204;
`endif

  logic               CLOCK_50 = 1'b0;
  logic               RESET_N;
  logic               INCREMENT_ANGLE;
  logic               frame_start;
  logic signed [31:0] sin_out, cos_out;
  logic [4:0]         ANGLE_ADDRESS;
  logic [7:0]         vtx_rd_idx;
  logic signed [31:0] vtx_x_in, vtx_y_in;
  logic               wr_en;
  logic [7:0]         wr_idx;
  logic [8:0]         wr_x, wr_y;
  logic               busy, frame_done;

  logic signed [31:0] sin_rom [0:31];
  logic signed [31:0] cos_rom [0:31];
  logic signed [31:0] vx [0:255];
  logic signed [31:0] vy [0:255];
  logic [8:0]         wx [0:17];
  logic [8:0]         wy [0:17];
  int                 wcount = 0;
  int                 fdcount = 0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  rotation_scheduler dut (
    .CLOCK_50        (CLOCK_50),
    .RESET_N         (RESET_N),
    .INCREMENT_ANGLE (INCREMENT_ANGLE),
    .frame_start     (frame_start),
    .sin_out         (sin_out),
    .cos_out         (cos_out),
    .ANGLE_ADDRESS   (ANGLE_ADDRESS),
    .vtx_rd_idx      (vtx_rd_idx),
    .vtx_x_in        (vtx_x_in),
    .vtx_y_in        (vtx_y_in),
    .wr_en           (wr_en),
    .wr_idx          (wr_idx),
    .wr_x            (wr_x),
    .wr_y            (wr_y),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One-cycle ROM and vertex table.
  always @(posedge CLOCK_50) begin
    sin_out  <= sin_rom[ANGLE_ADDRESS];
    cos_out  <= cos_rom[ANGLE_ADDRESS];
    vtx_x_in <= vx[vtx_rd_idx];
    vtx_y_in <= vy[vtx_rd_idx];
  end

  always @(negedge CLOCK_50) begin
    if (wr_en) begin
      wcount = wcount + 1;
      if (wr_idx < 8'd18) begin
        wx[wr_idx] = wr_x;
        wy[wr_idx] = wr_y;
      end
    end
    if (frame_done) fdcount = fdcount + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_inc();
    @(negedge CLOCK_50); INCREMENT_ANGLE = 1'b1;
    @(negedge CLOCK_50); INCREMENT_ANGLE = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!frame_done && cyc < 1000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
  endtask

  task automatic run_pass(output int lat, output int nwr);
    int base;
    base = wcount;
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    wait_done(lat);
    nwr = wcount - base;
  endtask

  initial begin
    int lat, nwr, base, fbase, guard;
    for (int i = 0; i < 32; i++) begin
      sin_rom[i] = 0;
      cos_rom[i] = 32768;
    end
    sin_rom[1] = 32768;
    cos_rom[1] = 0;
    for (int i = 0; i < 256; i++) begin
      vx[i] = (10 + i) * 32768;
      vy[i] = (200 + i) * 32768;
    end
    vx[0] = 140 * 32768;  vy[0] = 120 * 32768;
    vx[1] = -50 * 32768;  vy[1] = 30 * 32768;
    vx[2] = 600 * 32768;  vy[2] = 700 * 32768;
    vx[3] = 77 * 32768;   vy[3] = -5 * 32768;

    RESET_N = 1'b0; INCREMENT_ANGLE = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_angle", ANGLE_ADDRESS, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_vtx_rd_idx", vtx_rd_idx, 0);

    RESET_N = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("armed_no_write", wcount, 0);

    // First pass: identity angle, no advance.
    run_pass(lat, nwr);
    check("p1_latency", lat, LAT_EXP);
    check("p1_writes", nwr, 18);
    check("p1_angle", ANGLE_ADDRESS, 0);
    check("p1_x0", wx[0], 140);
    check("p1_y0", wy[0], 120);
    check("p1_x1_neg_sat", wx[1], 0);
    check("p1_x2_hi_sat", wx[2], 511);
    check("p1_y2_hi_sat", wy[2], 511);
    check("p1_x3", wx[3], 77);
    check("p1_y3_neg_sat", wy[3], 0);
    check("p1_x17", wx[17], 27);
    check("p1_y17", wy[17], 217);

    // Idle: frame_start alone does nothing.
    base = wcount;
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    check("idle_no_write", wcount - base, 0);
    check("idle_angle", ANGLE_ADDRESS, 0);

    // Step to angle 1: cos=0, sin=1.0
    pulse_inc();
    run_pass(lat, nwr);
    check("p2_angle", ANGLE_ADDRESS, 1);
    check("p2_latency", lat, LAT_EXP);
    check("p2_x0", wx[0], 120);
    check("p2_y0", wy[0], Y_ROT0);
    check("p2_x4", wx[4], 204);
    check("p2_y4", wy[4], Y_ROT4);

    // Requests while busy collapse to one; frame_start while busy is ignored.
    pulse_inc();
    base = wcount;
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    check("busy_mid_pass", busy, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_inc();
      repeat (5) @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    wait_done(lat);
    check("p3_done_seen", frame_done, 1);
    check("p3_writes", wcount - base, 18);
    repeat (5) @(negedge CLOCK_50);
    check("p3_angle", ANGLE_ADDRESS, 2);
    run_pass(lat, nwr);
    check("p4_angle", ANGLE_ADDRESS, 3);
    check("p4_writes", nwr, 18);
    base = wcount;
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    check("no_extra_step_writes", wcount - base, 0);
    check("no_extra_step_angle", ANGLE_ADDRESS, 3);

    // Walk to the last ROM entry, then wrap.
    for (int k = 0; k < 6; k++) begin
      pulse_inc();
      run_pass(lat, nwr);
    end
    check("angle_9", ANGLE_ADDRESS, 9);
    pulse_inc();
    run_pass(lat, nwr);
    check("wrap_angle", ANGLE_ADDRESS, 0);
    check("wrap_latency", lat, LAT_EXP);

    // Reset in the middle of the pass at vertex 5.
    pulse_inc();
    @(negedge CLOCK_50); frame_start = 1'b1;
    @(negedge CLOCK_50); frame_start = 1'b0;
    guard = 0;
    while (!(wr_en && wr_idx == 8'd5) && guard < 500) begin
      @(negedge CLOCK_50);
      guard++;
    end
    check("reach_vtx5", guard < 500, 1);
    fbase = fdcount;
    RESET_N = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_angle", ANGLE_ADDRESS, 0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    base = wcount;
    repeat (40) @(negedge CLOCK_50);
    check("abort_no_write", wcount - base, 0);
    check("abort_no_done", fdcount - fbase, 0);

    // Post-reset pass is armed at angle 0 with no advance.
    run_pass(lat, nwr);
    check("rearm_angle", ANGLE_ADDRESS, 0);
    check("rearm_latency", lat, LAT_EXP);
    check("rearm_writes", nwr, 18);
    check("rearm_x0", wx[0], 140);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
